// File: rtl/handshake_fifo_stage_pkg.sv
// Shared constants and helpers for the handshake FIFO stage and its storage array.
package handshake_fifo_stage_pkg;

  // Width of the ack pulse presented to the downstream node, in cycles.
  localparam int ACK_PULSE_CYCLES = 1;

  // Reset value used for counters and the default dout after reset.
  localparam int RESET_VALUE = 0;

  // Throughput counters are free-running and wrap naturally.
  localparam int COUNT_WIDTH = 32;

  // Number of bits needed to address 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for the FIFO stage: one synchronous write port and a
// combinational read port, so the popped word can be registered into dout.
module handshake_fifo_mem
  import handshake_fifo_stage_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(depth)-1:0]   waddr,
  input  logic [data_width-1:0]     wdata,
  input  logic [clog2(depth)-1:0]   raddr,
  output logic [data_width-1:0]     rdata
);

  localparam int AW = clog2(depth);

  logic [data_width-1:0] r_mem [depth];

  // Contents are never reset: pointers and level define which words are valid.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (we && (waddr == AW'(gi))) begin
          r_mem[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/handshake_fifo_stage.sv
// Elastic buffer node: requests words from upstream with req_l/ack_l and
// answers downstream req_r with a one-cycle ack_r pulse carrying dout.
module handshake_fifo_stage
  import handshake_fifo_stage_pkg::*;
#(
  parameter int                    data_width    = 32,
  parameter int                    depth         = 4,
  parameter logic [data_width-1:0] initial_value = data_width'(RESET_VALUE)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    req_l,
  input  logic                    ack_l,
  input  logic [data_width-1:0]   din,
  input  logic                    req_r,
  output logic                    ack_r,
  output logic [data_width-1:0]   dout,
  output logic [clog2(depth):0]   level,
  output logic [COUNT_WIDTH-1:0]  count_in,
  output logic [COUNT_WIDTH-1:0]  count_out,
  output logic                    err
);

  localparam int AW = clog2(depth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(depth);

  logic                        r_req_l;
  logic [ACK_PULSE_CYCLES-1:0] r_ack_sr;
  logic [data_width-1:0]       r_dout;
  logic [AW-1:0]               r_wptr;
  logic [AW-1:0]               r_rptr;
  logic [LW-1:0]               r_level;
  logic [COUNT_WIDTH-1:0]      r_count_in;
  logic [COUNT_WIDTH-1:0]      r_count_out;
  logic                        r_err;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_stray_ack;
  logic                        w_not_full;
  logic                        w_not_empty;
  logic                        w_ack_busy;
  logic [data_width-1:0]       w_rdata;
  logic [LW-1:0]               w_level_next;

  handshake_fifo_mem #(
    .data_width (data_width),
    .depth      (depth)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (din),
    .raddr (r_rptr),
    .rdata (w_rdata)
  );

  // Pop decisions use the registered level, so a word written on this edge
  // cannot be returned on the same edge.
  always_comb begin
    w_not_full  = (r_level < FULL_LEVEL);
    w_not_empty = (r_level != '0);
    w_ack_busy  = |r_ack_sr;
    w_push      = r_req_l & ack_l;
    w_stray_ack = ack_l & ~r_req_l;
    w_pop       = req_r & ~w_ack_busy & w_not_empty;
  end

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_l     <= 1'b0;
      r_ack_sr    <= '0;
      r_dout      <= initial_value;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_count_in  <= COUNT_WIDTH'(RESET_VALUE);
      r_count_out <= COUNT_WIDTH'(RESET_VALUE);
      r_err       <= 1'b0;
    end else begin
      r_level <= w_level_next;

      // A single outstanding request, raised only while a slot is free,
      // guarantees every accepted word has room.
      if (w_push) begin
        r_wptr     <= r_wptr + AW'(1);
        r_count_in <= r_count_in + COUNT_WIDTH'(1);
        r_req_l    <= 1'b0;
      end else if (!r_req_l && w_not_full) begin
        r_req_l <= 1'b1;
      end

      if (w_stray_ack) begin
        r_err <= 1'b1;
      end

      if (w_pop) begin
        r_ack_sr    <= '1;
        r_dout      <= w_rdata;
        r_rptr      <= r_rptr + AW'(1);
        r_count_out <= r_count_out + COUNT_WIDTH'(1);
      end else begin
        r_ack_sr <= r_ack_sr >> 1;
      end
    end
  end

  assign req_l     = r_req_l;
  assign ack_r     = r_ack_sr[0];
  assign dout      = r_dout;
  assign level     = r_level;
  assign count_in  = r_count_in;
  assign count_out = r_count_out;
  assign err       = r_err;

endmodule
